// File: rtl/iob_seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner: blank codes,
// the active-low hex segment table and default timing.
package iob_seg7_pkg;

  localparam int unsigned DIGITS_DEF       = 4;
  localparam int unsigned DIGIT_CYCLES_DEF = 100000;
  localparam int unsigned BLANK_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF        = 17;

  localparam logic [3:0] AN_OFF = 4'hF;
  localparam logic [6:0] CA_OFF = 7'h7F;

  // Indexed by hex value; element 0 is the rightmost entry of the concatenation.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/iob_seg7_dec.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module iob_seg7_dec
  import iob_seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_CODES[hex_i];
  end

endmodule

// File: rtl/iob_seg7_scan.sv
// Time-multiplexed common-anode display driver with frame-synchronous data
// updates, inter-digit blanking, per-digit enables and leading-zero suppression.
module iob_seg7_scan
  import iob_seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = DIGITS_DEF,
  parameter int unsigned DIGIT_CYCLES = DIGIT_CYCLES_DEF,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        data_we_i,
  input  logic [3:0]  dig_en_i,
  input  logic        lz_en_i,
  output logic [3:0]  disp_an_o,
  output logic [6:0]  disp_ca_o,
  output logic        frame_o
);

  localparam int unsigned      DigW     = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntBlank = CNT_W'(BLANK_CYCLES);
  localparam logic [DigW-1:0]  DigLast  = DigW'(DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DigW-1:0]  dig_q, dig_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       ca_q, ca_d;
  logic             frame_q, frame_d;

  logic       slot_end;
  logic       frame_end;
  logic       blank;
  logic       suppress;
  logic [3:0] zero_from;
  logic [3:0] nibble;
  logic [6:0] seg;

  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (dig_q == DigLast);
  assign blank     = (cnt_q < CntBlank);
  assign nibble    = active_q[4*dig_q +: 4];

  // zero_from[k]: nibbles k..3 of the displayed value are all zero.
  always_comb begin
    zero_from[3] = (active_q[15:12] == 4'h0);
    zero_from[2] = (active_q[11:8]  == 4'h0) && zero_from[3];
    zero_from[1] = (active_q[7:4]   == 4'h0) && zero_from[2];
    zero_from[0] = (active_q[3:0]   == 4'h0) && zero_from[1];
  end

  assign suppress = !dig_en_i[dig_q] ||
                    (lz_en_i && (dig_q != '0) && zero_from[dig_q]);

  iob_seg7_dec u_dec (
    .hex_i (nibble),
    .seg_o (seg)
  );

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    dig_d    = slot_end ? dig_q + 1'b1 : dig_q;
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (data_we_i) begin
      pend_d   = data_i;
      pend_v_d = 1'b1;
    end
    // A write landing on the boundary bypasses the pending register.
    if (frame_end) begin
      if (data_we_i) begin
        active_d = data_i;
      end else if (pend_v_q) begin
        active_d = pend_q;
      end
      pend_v_d = 1'b0;
    end

    if (blank || suppress) begin
      an_d = AN_OFF;
      ca_d = CA_OFF;
    end else begin
      an_d = ~(4'b0001 << dig_q);
      ca_d = seg;
    end
    frame_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      dig_q    <= '0;
      active_q <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
      an_q     <= AN_OFF;
      ca_q     <= CA_OFF;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      ca_q     <= ca_d;
      frame_q  <= frame_d;
    end
  end

  assign disp_an_o = an_q;
  assign disp_ca_o = ca_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_iob_seg7_scan.sv
// Scoreboard bench for iob_seg7_scan with a short scan (8 cycles/slot, 2 blank).
module tb_iob_seg7_scan;

  localparam int unsigned DC = 8;
  localparam int unsigned BC = 2;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        data_we;
  logic [3:0]  dig_en;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        frame;

  iob_seg7_scan #(
    .DIGITS       (4),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data),
    .data_we_i (data_we),
    .dig_en_i  (dig_en),
    .lz_en_i   (lz_en),
    .disp_an_o (an),
    .disp_ca_o (ca),
    .frame_o   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ca;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_cnt, m_dig;
  logic [15:0] m_active, m_pend;
  bit          m_pendv;
  int          frames_seen;
  bit          seen_5;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predict the pins for the coming edge, advance the model, then compare.
  task automatic step();
    exp_t       e;
    exp_t       g;
    logic [3:0] nib;
    bit         blank, shown;
    if (rst) begin
      e.an = 4'hF; e.ca = 7'h7F; e.fr = 1'b0;
      m_cnt = 0; m_dig = 0; m_active = 16'h0; m_pend = 16'h0; m_pendv = 0;
    end else begin
      nib   = m_active[4*m_dig +: 4];
      blank = (m_cnt < BC);
      shown = dig_en[m_dig] && !(lz_en && m_dig > 0 && ((m_active >> (4 * m_dig)) == 16'h0));
      if (!blank && shown) begin
        e.an = ~(4'b0001 << m_dig);
        e.ca = seg_tab[nib];
      end else begin
        e.an = 4'hF;
        e.ca = 7'h7F;
      end
      e.fr = (m_cnt == DC - 1 && m_dig == 3);
      if (e.fr) begin
        if (data_we) m_active = data;
        else if (m_pendv) m_active = m_pend;
        m_pendv = 0;
        if (data_we) m_pend = data;
      end else if (data_we) begin
        m_pend  = data;
        m_pendv = 1;
      end
      if (m_cnt == DC - 1) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (frame === 1'b1) frames_seen++;
    if (ca === 7'h12) seen_5 = 1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 16'd0, 16'd1);
    end else begin
      g = exp_q.pop_front();
      check_val("an", {12'h0, an}, {12'h0, g.an});
      check_val("ca", {9'h0, ca}, {9'h0, g.ca});
      check_val("frame", {15'h0, frame}, {15'h0, g.fr});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [15:0] v);
    data    = v;
    data_we = 1'b1;
    step();
    data_we = 1'b0;
  endtask

  task automatic wait_model(input int dig, input int cnt);
    for (int i = 0; i < 100 && !(m_dig == dig && m_cnt == cnt); i++) step();
  endtask

  initial begin
    rst = 1'b1; data = 16'h0; data_we = 1'b0; dig_en = 4'hF; lz_en = 1'b0;
    m_cnt = 0; m_dig = 0; m_active = 16'h0; m_pend = 16'h0; m_pendv = 0;
    frames_seen = 0; seen_5 = 0;

    run(3);
    rst = 1'b0;
    frames_seen = 0;
    run(64);
    check_val("frames_in_64", 16'(frames_seen), 16'd2);

    wait_model(1, 3);
    write(16'h12AF);
    run(80);

    lz_en = 1'b1;
    write(16'h0030);
    run(80);
    write(16'h0000);
    run(80);
    lz_en = 1'b0;

    wait_model(0, 3);
    write(16'h1111);
    run(5);
    write(16'h2222);
    run(40);
    wait_model(3, DC - 1);
    write(16'h3333);
    run(40);

    dig_en = 4'b0101;
    write(16'h8888);
    run(80);
    dig_en = 4'hF;

    wait_model(3, DC - 1);
    step();
    run(4);
    write(16'h5555);
    run(6);
    seen_5 = 0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(80);
    check_val("no_5555", {15'h0, seen_5}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_seg7_scan.md
Name: iob_seg7_scan

Overview:
Time-multiplexed 4-digit 7-segment display driver, directly downstream of the GPIO core. It consumes a 16-bit hex value (e.g. the GPIO result register) and drives the board's common-anode display via `disp_an_o` and `disp_ca_o`, replacing software bit-banging of the anode/cathode registers. It provides tear-free frame-synchronous updates, inter-digit ghost blanking, per-digit enables and optional leading-zero suppression.

Parameters:
DIGITS, 4, number of digits scanned; fixed at 4 in this revision.
DIGIT_CYCLES, 100000, clock cycles per digit slot, blank phase included; must be >= 2.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < DIGIT_CYCLES.
CNT_W, 17, slot counter width; 2**CNT_W >= DIGIT_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
data_i  in  16  four hex nibbles; [3:0] = digit 0 (rightmost, least significant)
data_we_i  in  1  single-cycle write strobe for data_i
dig_en_i  in  4  per-digit enable; 0 forces that anode off
lz_en_i  in  1  leading-zero suppression enable
disp_an_o  out  4  anodes, active-low, one-hot-low when driving
disp_ca_o  out  7  cathodes {g,f,e,d,c,b,a}, active-low
frame_o  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Single clock `clk`; reset is synchronous and active-high on `rst`. All state is sampled on the rising edge.
- Reset values:
  - cnt=0, dig=0, active=16'h0000, pend=16'h0000, pend_v=0.
  - disp_an_o=4'hF, disp_ca_o=7'h7F, frame_o=0.
- Counters:
  - cnt increments every cycle and wraps at DIGIT_CYCLES-1 to 0.
  - On that wrap, dig increments and wraps 3 to 0.
- Frame boundary: the cycle with cnt==DIGIT_CYCLES-1 and dig==3.
- Phases:
  - BLANK when cnt < BLANK_CYCLES.
  - DRIVE otherwise.
  - The phase is combinational from cnt; there is no separate state register.
- Outputs are registered, with 1-cycle latency from cnt/dig to pins:
  - In BLANK: an=4'hF, ca=7'h7F.
  - In DRIVE, digit shown: an=~(4'b0001<<dig), ca=seg(active[4*dig+:4]).
  - In DRIVE, digit suppressed: an=4'hF, ca=7'h7F.
- A digit is suppressed when dig_en_i[dig]==0, or when lz_en_i==1, dig>0 and nibbles dig..3 of active are all zero. Digit 0 is never suppressed by lz_en_i.
- dig_en_i and lz_en_i are sampled live each cycle and are not frame-synchronised.
- Update handshake:
  - data_we_i loads pend<=data_i and sets pend_v.
  - At the frame boundary, if pend_v is set: active<=pend and pend_v clears.
  - Multiple writes in one frame: the last write wins.
  - data_we_i asserted on the boundary cycle: data_i goes straight to active, pend_v ends cleared, and the write is not deferred.
- frame_o is registered high for exactly one cycle following each boundary cycle.
- Segment codes, active-low gfedcba, digits 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- Reset asserted mid-frame: on the next edge all state returns to reset values, the pending write is discarded and the outputs are off. Scanning restarts at dig=0, cnt=0 in the cycle rst deasserts.
- There is no bus interface; the parent (GPIO/SoC top) ties data_i and data_we_i to a software register and its write enable.

Decomposition:
- Shared package/header iob_seg7_pkg:
  - 16-entry segment code table.
  - Blank constants AN_OFF=4'hF and CA_OFF=7'h7F.
  - Parameter defaults.
- One sub-module, iob_seg7_dec: combinational 4-bit hex to 7-bit active-low segment decoder, instantiated once and driven by the muxed nibble.
- Top block contains the counters, pending/active registers, suppression logic and output registers.

Test Plan:
(Bench overrides DIGIT_CYCLES=8, BLANK_CYCLES=2.)
- Reset: hold rst 3 cycles, release with data_we_i=0, dig_en_i=F, lz_en_i=0 -> during rst an=F, ca=7F, frame_o=0; after release, slot 0 cycles 2..7 (pins lag 1 cycle) show an=E, ca=40; frame_o pulses once every 32 cycles.
- Write 16'h12AF mid-frame -> display unchanged until the boundary. The next frame shows:
  - an=E ca=0E
  - an=D ca=08
  - an=B ca=24
  - an=7 ca=79
  - with an=F for the first 2 cycles of every slot.
- Leading zeros with lz_en_i=1:
  - data 16'h0030 -> digits 3,2 an=F all frame; digit1 ca=30; digit0 ca=40.
  - data 16'h0000 -> only digit0 lit, ca=40.
- Writes: 16'h1111 then 16'h2222 in the same frame -> next frame shows 2 on all digits. A write of 16'h3333 exactly on the boundary cycle -> the following frame shows 3 with no one-frame delay.
- dig_en_i=4'b0101 with active 16'h8888 -> only an=E and an=B ever asserted; slots 1 and 3 an=F throughout.
- Reset mid-frame after a pending write of 16'h5555 -> outputs F/7F next cycle; after release the display shows 0000, and 5555 never appears.
